// File: rtl/sr_sequencer.sv
// Purpose: drives S/R of an external SR latch from two async requests (sync, debounce, edge-detect, pulse).
// Latency: S/R first high SYNC_STAGES+DEBOUNCE+1 edges after the request is first sampled high.
// Backpressure: events arriving while busy are held in one pending bit per input (repeats coalesce).
//
// Ports:
//   CLK       - system clock, all logic on rising edge
//   Reset     - synchronous, active-high reset
//   SetReq_a  - asynchronous set request (active high)
//   ClrReq_a  - asynchronous clear request (active high)
//   S, R      - registered, mutually exclusive latch drives
//   Qstate    - expected latch state (1 = set)
//   Busy      - high in SET_PULSE, CLR_PULSE and GAP
//   Conflict  - sticky: set and clear events seen in the same cycle
module sr_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int PULSE_LEN   = 2
) (
    input  logic CLK,
    input  logic Reset,
    input  logic SetReq_a,
    input  logic ClrReq_a,
    output logic S,
    output logic R,
    output logic Qstate,
    output logic Busy,
    output logic Conflict
);

    localparam int DB_W = (DEBOUNCE  < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int PC_W = (PULSE_LEN < 2) ? 1 : $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_PULSE = 2'd1,
        CLR_PULSE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t state;

    // Index 0 carries the set request, index 1 the clear request.
    logic [1:0]             req_a;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [DB_W-1:0]        db_cnt [2];
    logic [1:0]             lvl_q;
    logic [1:0]             lvl_prev_q;
    logic [1:0]             evt;
    logic                   set_evt;
    logic                   clr_evt;
    logic                   pend_set;
    logic                   pend_clr;
    logic [PC_W-1:0]        pulse_cnt;

    assign req_a   = {ClrReq_a, SetReq_a};
    // Rising edge of the debounced level; falling edges are ignored.
    assign evt     = lvl_q & ~lvl_prev_q;
    assign set_evt = evt[0];
    assign clr_evt = evt[1];

    // Front end: synchroniser chain and debounce counter per input.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= '0;
                db_cnt[i] <= '0;
            end
            lvl_q      <= '0;
            lvl_prev_q <= '0;
        end else begin
            lvl_prev_q <= lvl_q;
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], req_a[i]};
                if (sync_q[i][SYNC_STAGES-1] != lvl_q[i]) begin
                    // Flip on the cycle the count would reach DEBOUNCE.
                    if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                        lvl_q[i]  <= ~lvl_q[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Command FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            S         <= 1'b0;
            R         <= 1'b0;
            Qstate    <= 1'b0;
            Busy      <= 1'b0;
            Conflict  <= 1'b0;
            pend_set  <= 1'b0;
            pend_clr  <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            if (set_evt && clr_evt) begin
                Conflict <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (clr_evt || pend_clr) begin
                        // Clear wins; a simultaneous set waits as pending.
                        pend_clr <= 1'b0;
                        pend_set <= pend_set | set_evt;
                        if (Qstate) begin
                            state     <= CLR_PULSE;
                            R         <= 1'b1;
                            Busy      <= 1'b1;
                            pulse_cnt <= PC_W'(1);
                        end
                    end else if (set_evt || pend_set) begin
                        pend_set <= 1'b0;
                        if (!Qstate) begin
                            state     <= SET_PULSE;
                            S         <= 1'b1;
                            Busy      <= 1'b1;
                            pulse_cnt <= PC_W'(1);
                        end
                    end
                end

                SET_PULSE, CLR_PULSE: begin
                    pend_set <= pend_set | set_evt;
                    pend_clr <= pend_clr | clr_evt;
                    // pulse_cnt counts drive cycles already completed.
                    if (pulse_cnt == PC_W'(PULSE_LEN)) begin
                        state  <= GAP;
                        S      <= 1'b0;
                        R      <= 1'b0;
                        Qstate <= (state == SET_PULSE);
                    end else begin
                        pulse_cnt <= pulse_cnt + PC_W'(1);
                    end
                end

                GAP: begin
                    pend_set <= pend_set | set_evt;
                    pend_clr <= pend_clr | clr_evt;
                    state    <= IDLE;
                    Busy     <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    S     <= 1'b0;
                    R     <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_sequencer.sv
// Purpose: directed self-checking bench for sr_sequencer with default parameters.
// Latency: expected waveforms are hand-derived per edge (edge 1 = first edge sampling a request).
// Backpressure: covers pending requests during busy pulses and simultaneous set/clear.
module tb_sr_sequencer;

    logic CLK      = 1'b0;
    logic Reset    = 1'b1;
    logic SetReq_a = 1'b0;
    logic ClrReq_a = 1'b0;
    logic S, R, Qstate, Busy, Conflict;

    int tests       = 0;
    int fails       = 0;
    int overlap_cnt = 0;

    // Bit k holds the output value sampled just after edge k of the last run.
    logic [31:0] s_v, r_v, q_v, b_v, c_v;

    sr_sequencer #(
        .SYNC_STAGES(2),
        .DEBOUNCE   (4),
        .PULSE_LEN  (2)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .SetReq_a(SetReq_a),
        .ClrReq_a(ClrReq_a),
        .S       (S),
        .R       (R),
        .Qstate  (Qstate),
        .Busy    (Busy),
        .Conflict(Conflict)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (S === 1'b1 && R === 1'b1) overlap_cnt++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Run n edges; requests/reset change just before the named edge index.
    task automatic run(input int n, input int set_on, input int set_off,
                       input int clr_on, input int clr_off, input int rst_at);
        s_v = '0; r_v = '0; q_v = '0; b_v = '0; c_v = '0;
        for (int k = 1; k <= n; k++) begin
            if (k == set_on)  SetReq_a = 1'b1;
            if (k == set_off) SetReq_a = 1'b0;
            if (k == clr_on)  ClrReq_a = 1'b1;
            if (k == clr_off) ClrReq_a = 1'b0;
            Reset = (k == rst_at);
            step();
            s_v[k] = S; r_v[k] = R; q_v[k] = Qstate; b_v[k] = Busy; c_v[k] = Conflict;
        end
        Reset = 1'b0;
    endtask

    task automatic do_reset();
        SetReq_a = 1'b0;
        ClrReq_a = 1'b0;
        Reset    = 1'b1;
        step();
        step();
        Reset    = 1'b0;
    endtask

    task automatic test_reset();
        SetReq_a = 1'b0;
        ClrReq_a = 1'b0;
        Reset    = 1'b1;
        step();
        step();
        tests++;
        if ({S, R, Qstate, Busy, Conflict} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs actual=%b required=00000", {S, R, Qstate, Busy, Conflict});
        end
        Reset = 1'b0;
        run(20, 0, 0, 0, 0, 0);
        tests++;
        if ((s_v | r_v | q_v | b_v | c_v) !== 32'h0) begin
            fails++;
            $display("FAIL reset_idle actual=%h required=00000000", s_v | r_v | q_v | b_v | c_v);
        end
    endtask

    task automatic test_set_latency();
        run(14, 1, 0, 0, 0, 0);
        tests++;
        if (s_v !== 32'h0000_0180) begin
            fails++; $display("FAIL set_lat_S actual=%h required=00000180", s_v);
        end
        tests++;
        if (b_v !== 32'h0000_0380) begin
            fails++; $display("FAIL set_lat_Busy actual=%h required=00000380", b_v);
        end
        tests++;
        if (q_v !== 32'h0000_7E00) begin
            fails++; $display("FAIL set_lat_Q actual=%h required=00007e00", q_v);
        end
        tests++;
        if (r_v !== 32'h0) begin
            fails++; $display("FAIL set_lat_R actual=%h required=00000000", r_v);
        end
        // Releasing the request is a falling edge: no action expected.
        run(20, 0, 1, 0, 0, 0);
        tests++;
        if ((s_v | r_v | b_v) !== 32'h0) begin
            fails++; $display("FAIL set_release_quiet actual=%h required=00000000", s_v | r_v | b_v);
        end
        tests++;
        if (q_v !== 32'h001F_FFFE) begin
            fails++; $display("FAIL set_release_Q actual=%h required=001ffffe", q_v);
        end
    endtask

    task automatic test_glitch();
        // ClrReq_a high for edges 1..3 only, Qstate is 1 from the previous test.
        run(15, 0, 0, 1, 4, 0);
        tests++;
        if (r_v !== 32'h0) begin
            fails++; $display("FAIL glitch_R actual=%h required=00000000", r_v);
        end
        tests++;
        if (q_v !== 32'h0000_FFFE) begin
            fails++; $display("FAIL glitch_Q actual=%h required=0000fffe", q_v);
        end
        tests++;
        if (b_v !== 32'h0) begin
            fails++; $display("FAIL glitch_Busy actual=%h required=00000000", b_v);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        run(16, 1, 0, 1, 0, 0);
        tests++;
        if (c_v !== 32'h0001_FF80) begin
            fails++; $display("FAIL conflict_flag actual=%h required=0001ff80", c_v);
        end
        tests++;
        if (r_v !== 32'h0) begin
            fails++; $display("FAIL conflict_R actual=%h required=00000000", r_v);
        end
        tests++;
        if (s_v !== 32'h0000_0300) begin
            fails++; $display("FAIL conflict_S actual=%h required=00000300", s_v);
        end
        tests++;
        if (q_v !== 32'h0001_FC00) begin
            fails++; $display("FAIL conflict_Q actual=%h required=0001fc00", q_v);
        end
        tests++;
        if (b_v !== 32'h0000_0700) begin
            fails++; $display("FAIL conflict_Busy actual=%h required=00000700", b_v);
        end
        // Conflict is sticky after both requests are released.
        run(20, 0, 1, 0, 1, 0);
        tests++;
        if (Conflict !== 1'b1) begin
            fails++; $display("FAIL conflict_sticky actual=%b required=1", Conflict);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Clear request starts one edge after set, its event lands during SET_PULSE.
        run(18, 1, 0, 2, 0, 0);
        tests++;
        if (s_v !== 32'h0000_0180) begin
            fails++; $display("FAIL b2b_S actual=%h required=00000180", s_v);
        end
        tests++;
        if (r_v !== 32'h0000_1800) begin
            fails++; $display("FAIL b2b_R actual=%h required=00001800", r_v);
        end
        tests++;
        if (q_v !== 32'h0000_1E00) begin
            fails++; $display("FAIL b2b_Q actual=%h required=00001e00", q_v);
        end
        tests++;
        if (b_v !== 32'h0000_3B80) begin
            fails++; $display("FAIL b2b_Busy actual=%h required=00003b80", b_v);
        end
        tests++;
        if (c_v !== 32'h0) begin
            fails++; $display("FAIL b2b_Conflict actual=%h required=00000000", c_v);
        end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        // Reset sampled on edge 8, the edge that would begin the second S cycle.
        run(20, 1, 8, 0, 0, 8);
        tests++;
        if (s_v !== 32'h0000_0080) begin
            fails++; $display("FAIL rst_mid_S actual=%h required=00000080", s_v);
        end
        tests++;
        if (b_v !== 32'h0000_0080) begin
            fails++; $display("FAIL rst_mid_Busy actual=%h required=00000080", b_v);
        end
        tests++;
        if ((q_v | r_v) !== 32'h0) begin
            fails++; $display("FAIL rst_mid_QR actual=%h required=00000000", q_v | r_v);
        end
    endtask

    task automatic test_invariant();
        tests++;
        if (overlap_cnt !== 0) begin
            fails++; $display("FAIL s_and_r_overlap actual=%0d required=0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_set_latency();
        test_glitch();
        test_conflict();
        test_back_to_back();
        test_reset_mid_pulse();
        test_invariant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
